// File: rtl/psr_writeback.sv
// psr_writeback: writeback stage behind the CR16 ALU.
//   - One-entry writeback register with a valid/ready handshake toward the register file.
//   - The Processor Status Register {N,Z,F,L,C} is merged from the ALU status under a
//     per-opcode flag mask. An explicit LPR write (I_PSR_WE) overrides every bit.
//   - The Bcond/Scond condition code is evaluated against the PSR.
// Optional feature macro: PSR_BYPASS_EN
//   - Defined: conditions see the next-state PSR, so a CMP and the branch that depends on
//     it resolve in the same cycle. This adds a combinational path I_STATUS -> O_COND_TRUE.
//   - Undefined (default): conditions see the registered PSR only.
module psr_writeback #(
    parameter int P_WIDTH    = 16,
    parameter int P_REG_BITS = 4
) (
    input  logic                  I_CLK,
    input  logic                  I_RESET,
    input  logic                  I_VALID,
    output logic                  O_READY,
    input  logic [3:0]            I_OPCODE,
    input  logic                  I_CMP,
    input  logic [P_WIDTH-1:0]    I_RESULT,
    input  logic [4:0]            I_STATUS,
    input  logic [P_REG_BITS-1:0] I_DEST,
    output logic                  O_WB_VALID,
    input  logic                  I_WB_READY,
    output logic [P_REG_BITS-1:0] O_WB_REG,
    output logic [P_WIDTH-1:0]    O_WB_DATA,
    input  logic                  I_PSR_WE,
    input  logic [4:0]            I_PSR_WDATA,
    output logic [4:0]            O_PSR,
    input  logic [3:0]            I_COND,
    output logic                  O_COND_TRUE
);

    // PSR bit positions {N,Z,F,L,C} = [4:0]
    localparam int PSR_N = 4;
    localparam int PSR_Z = 3;
    localparam int PSR_F = 2;
    localparam int PSR_L = 1;
    localparam int PSR_C = 0;

    // Arithmetic results touch carry/overflow; compares touch the ordering flags.
    localparam logic [4:0] MASK_ARITH = 5'b00101;   // C, F
    localparam logic [4:0] MASK_CMP   = 5'b11010;   // N, Z, L
    localparam logic [4:0] MASK_NONE  = 5'b00000;

    logic                  r_wb_valid;
    logic [P_REG_BITS-1:0] r_wb_reg;
    logic [P_WIDTH-1:0]    r_wb_data;
    logic [4:0]            r_psr;

    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_new_entry;
    logic [4:0]            w_flag_mask;
    logic [4:0]            w_psr_merged;
    logic [4:0]            w_psr_next;
    logic [4:0]            w_psr_cond;

    // Evaluate a 4-bit condition code against a PSR value.
    function automatic logic f_cond(input logic [3:0] cond, input logic [4:0] psr);
        logic v;
        v = 1'b0;
        case (cond)
            4'd0:  v = psr[PSR_Z];
            4'd1:  v = ~psr[PSR_Z];
            4'd2:  v = psr[PSR_C];
            4'd3:  v = ~psr[PSR_C];
            4'd4:  v = psr[PSR_L];
            4'd5:  v = ~psr[PSR_L];
            4'd6:  v = psr[PSR_N];
            4'd7:  v = ~psr[PSR_N];
            4'd8:  v = psr[PSR_F];
            4'd9:  v = ~psr[PSR_F];
            4'd10: v = ~psr[PSR_L] & ~psr[PSR_Z];
            4'd11: v = psr[PSR_L] | psr[PSR_Z];
            4'd12: v = ~psr[PSR_N] & ~psr[PSR_Z];
            4'd13: v = psr[PSR_N] | psr[PSR_Z];
            4'd14: v = 1'b1;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    // The slot is free when empty or when its entry drains this cycle.
    assign w_ready     = ~r_wb_valid | I_WB_READY;
    assign w_xfer      = I_VALID & w_ready;
    assign w_new_entry = w_xfer & ~I_CMP;

    // Select which PSR bits the incoming result is allowed to change.
    always_comb begin
        w_flag_mask = MASK_NONE;
        case (I_OPCODE)
            4'd0, 4'd1, 4'd2, 4'd3: w_flag_mask = MASK_ARITH;
            4'd5:                   w_flag_mask = I_CMP ? MASK_CMP : MASK_ARITH;
            default:                w_flag_mask = MASK_NONE;
        endcase
    end

    // Next-state PSR: explicit LPR write has priority over any flag update.
    always_comb begin
        w_psr_merged = (r_psr & ~w_flag_mask) | (I_STATUS & w_flag_mask);
        w_psr_next   = r_psr;
        if (I_PSR_WE) begin
            w_psr_next = I_PSR_WDATA;
        end else if (w_xfer) begin
            w_psr_next = w_psr_merged;
        end
    end

    // Writeback entry register: load on a non-compare transfer, clear valid on drain.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_wb_valid <= 1'b0;
            r_wb_reg   <= '0;
            r_wb_data  <= '0;
        end else begin
            if (w_new_entry) begin
                r_wb_valid <= 1'b1;
                r_wb_reg   <= I_DEST;
                r_wb_data  <= I_RESULT;
            end else if (I_WB_READY) begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    // Architectural PSR register.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_psr <= '0;
        end else begin
            r_psr <= w_psr_next;
        end
    end

`ifdef PSR_BYPASS_EN
    assign w_psr_cond = w_psr_next;
`else
    assign w_psr_cond = r_psr;
`endif

    assign O_READY     = w_ready;
    assign O_WB_VALID  = r_wb_valid;
    assign O_WB_REG    = r_wb_reg;
    assign O_WB_DATA   = r_wb_data;
    assign O_PSR       = r_psr;
    assign O_COND_TRUE = f_cond(I_COND, w_psr_cond);

endmodule

// File: tb/tb_psr_writeback.sv
// Directed bench for psr_writeback with hand-computed expected values.
module tb_psr_writeback;

    logic        I_CLK = 1'b0;
    logic        I_RESET;
    logic        I_VALID;
    logic        O_READY;
    logic [3:0]  I_OPCODE;
    logic        I_CMP;
    logic [15:0] I_RESULT;
    logic [4:0]  I_STATUS;
    logic [3:0]  I_DEST;
    logic        O_WB_VALID;
    logic        I_WB_READY;
    logic [3:0]  O_WB_REG;
    logic [15:0] O_WB_DATA;
    logic        I_PSR_WE;
    logic [4:0]  I_PSR_WDATA;
    logic [4:0]  O_PSR;
    logic [3:0]  I_COND;
    logic        O_COND_TRUE;

    int n_checks = 0;
    int n_errors = 0;

    psr_writeback #(.P_WIDTH(16), .P_REG_BITS(4)) u_dut (
        .I_CLK       (I_CLK),
        .I_RESET     (I_RESET),
        .I_VALID     (I_VALID),
        .O_READY     (O_READY),
        .I_OPCODE    (I_OPCODE),
        .I_CMP       (I_CMP),
        .I_RESULT    (I_RESULT),
        .I_STATUS    (I_STATUS),
        .I_DEST      (I_DEST),
        .O_WB_VALID  (O_WB_VALID),
        .I_WB_READY  (I_WB_READY),
        .O_WB_REG    (O_WB_REG),
        .O_WB_DATA   (O_WB_DATA),
        .I_PSR_WE    (I_PSR_WE),
        .I_PSR_WDATA (I_PSR_WDATA),
        .O_PSR       (O_PSR),
        .I_COND      (I_COND),
        .O_COND_TRUE (O_COND_TRUE)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_xfer(input logic v, input logic [3:0] op, input logic cmp,
                            input logic [15:0] res, input logic [4:0] st, input logic [3:0] dst);
        I_VALID  = v;
        I_OPCODE = op;
        I_CMP    = cmp;
        I_RESULT = res;
        I_STATUS = st;
        I_DEST   = dst;
    endtask

    task automatic tick;
        @(posedge I_CLK);
        #1;
    endtask

    // Condition table against PSR 5'b01111 (N=0 Z=1 F=1 L=1 C=1)
    logic [3:0] cond_code [8] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd10, 4'd11, 4'd12, 4'd15};
    logic       cond_exp  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  1'b1,  1'b0,  1'b0};

    logic bypass_exp;

    initial begin
`ifdef PSR_BYPASS_EN
        bypass_exp = 1'b1;
`else
        bypass_exp = 1'b0;
`endif
        I_RESET     = 1'b1;
        set_xfer(1'b0, 4'd0, 1'b0, 16'h0, 5'b0, 4'd0);
        I_WB_READY  = 1'b0;
        I_PSR_WE    = 1'b0;
        I_PSR_WDATA = 5'b0;
        I_COND      = 4'd0;
        repeat (2) @(posedge I_CLK);
        @(negedge I_CLK);
        I_RESET = 1'b0;
        #1;
        check("rst_wb_valid", 32'(O_WB_VALID), 32'd0);
        check("rst_psr",      32'(O_PSR),      32'd0);
        check("rst_ready",    32'(O_READY),    32'd1);

        // Build a stalled entry, then reset asynchronously in the middle of the stall
        @(negedge I_CLK);
        set_xfer(1'b1, 4'd0, 1'b0, 16'hABCD, 5'b11111, 4'd7);
        tick();
        check("pre_wb_valid", 32'(O_WB_VALID), 32'd1);
        check("pre_wb_data",  32'(O_WB_DATA),  32'hABCD);
        check("pre_psr",      32'(O_PSR),      32'h05);
        @(negedge I_CLK);
        set_xfer(1'b0, 4'd0, 1'b0, 16'h0, 5'b0, 4'd0);
        #2;
        I_RESET = 1'b1;
        #1;
        check("arst_wb_valid", 32'(O_WB_VALID), 32'd0);
        check("arst_wb_reg",   32'(O_WB_REG),   32'd0);
        check("arst_wb_data",  32'(O_WB_DATA),  32'd0);
        check("arst_psr",      32'(O_PSR),      32'd0);
        @(negedge I_CLK);
        I_RESET = 1'b0;
        #1;
        check("arst_ready", 32'(O_READY), 32'd1);

        // ADD transfer
        @(negedge I_CLK);
        I_WB_READY = 1'b1;
        set_xfer(1'b1, 4'd0, 1'b0, 16'h7FFF, 5'b10101, 4'd3);
        tick();
        check("add_wb_valid", 32'(O_WB_VALID), 32'd1);
        check("add_wb_data",  32'(O_WB_DATA),  32'h7FFF);
        check("add_wb_reg",   32'(O_WB_REG),   32'd3);
        check("add_psr",      32'(O_PSR),      32'h05);

        // CMP: flags only, old entry drains, data held
        @(negedge I_CLK);
        set_xfer(1'b1, 4'd5, 1'b1, 16'h1234, 5'b01010, 4'd9);
        tick();
        check("cmp_psr",      32'(O_PSR),      32'h0F);
        check("cmp_wb_valid", 32'(O_WB_VALID), 32'd0);
        check("cmp_wb_data",  32'(O_WB_DATA),  32'h7FFF);
        check("cmp_wb_reg",   32'(O_WB_REG),   32'd3);
        @(negedge I_CLK);
        set_xfer(1'b0, 4'd0, 1'b0, 16'h0, 5'b0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            I_COND = cond_code[i];
            #1;
            check($sformatf("cond_%0d", cond_code[i]), 32'(O_COND_TRUE), 32'(cond_exp[i]));
        end

        // Stall: entry and PSR hold while the register file refuses
        @(negedge I_CLK);
        set_xfer(1'b1, 4'd1, 1'b0, 16'h5555, 5'b00000, 4'd2);
        tick();
        check("stall_pre_psr",  32'(O_PSR),     32'h0A);
        check("stall_pre_data", 32'(O_WB_DATA), 32'h5555);
        @(negedge I_CLK);
        I_WB_READY = 1'b0;
        set_xfer(1'b1, 4'd0, 1'b0, 16'hAAAA, 5'b11111, 4'd4);
        #1;
        check("stall_ready_comb", 32'(O_READY), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ready", 32'(O_READY),    32'd0);
            check("stall_valid", 32'(O_WB_VALID), 32'd1);
            check("stall_data",  32'(O_WB_DATA),  32'h5555);
            check("stall_psr",   32'(O_PSR),      32'h0A);
        end
        @(negedge I_CLK);
        I_WB_READY = 1'b1;
        #1;
        check("unstall_ready", 32'(O_READY), 32'd1);
        tick();
        check("unstall_data",  32'(O_WB_DATA),  32'hAAAA);
        check("unstall_reg",   32'(O_WB_REG),   32'd4);
        check("unstall_valid", 32'(O_WB_VALID), 32'd1);
        check("unstall_psr",   32'(O_PSR),      32'h0F);

        // LPR write wins over a same-cycle ADD flag update
        @(negedge I_CLK);
        I_PSR_WE    = 1'b1;
        I_PSR_WDATA = 5'b10000;
        set_xfer(1'b1, 4'd0, 1'b0, 16'h0F0F, 5'b00101, 4'd5);
        tick();
        check("lpr_psr",     32'(O_PSR),     32'h10);
        check("lpr_wb_data", 32'(O_WB_DATA), 32'h0F0F);
        @(negedge I_CLK);
        I_PSR_WE = 1'b0;
        set_xfer(1'b0, 4'd0, 1'b0, 16'h0, 5'b0, 4'd0);
        I_COND = 4'd6;
        #1;
        check("lpr_gt", 32'(O_COND_TRUE), 32'd1);

        // Opcode 4 leaves the PSR alone; SUB updates C,F
        @(negedge I_CLK);
        set_xfer(1'b1, 4'd4, 1'b0, 16'h0004, 5'b11111, 4'd1);
        tick();
        check("op4_psr", 32'(O_PSR), 32'h10);
        @(negedge I_CLK);
        set_xfer(1'b1, 4'd5, 1'b0, 16'h0005, 5'b11111, 4'd6);
        tick();
        check("sub_psr",     32'(O_PSR),     32'h15);
        check("sub_wb_data", 32'(O_WB_DATA), 32'h0005);

        // Drain without transfer
        @(negedge I_CLK);
        set_xfer(1'b0, 4'd0, 1'b0, 16'h0, 5'b0, 4'd0);
        tick();
        check("drain_valid", 32'(O_WB_VALID), 32'd0);
        check("drain_data",  32'(O_WB_DATA),  32'h0005);
        check("drain_reg",   32'(O_WB_REG),   32'd6);

        // CMP with Z=1 and EQ evaluated in the same cycle (PSR Z currently 0)
        @(negedge I_CLK);
        I_COND = 4'd0;
        set_xfer(1'b1, 4'd5, 1'b1, 16'h0, 5'b01000, 4'd0);
        #1;
        check("same_cycle_eq", 32'(O_COND_TRUE), 32'(bypass_exp));
        tick();
        check("next_cycle_psr", 32'(O_PSR), 32'h0D);
        @(negedge I_CLK);
        set_xfer(1'b0, 4'd0, 1'b0, 16'h0, 5'b0, 4'd0);
        #1;
        check("next_cycle_eq", 32'(O_COND_TRUE), 32'd1);

        // LPR without any transfer
        @(negedge I_CLK);
        I_PSR_WE    = 1'b1;
        I_PSR_WDATA = 5'b01010;
        tick();
        check("lpr_only_psr", 32'(O_PSR), 32'h0A);
        @(negedge I_CLK);
        I_PSR_WE = 1'b0;
        I_COND   = 4'd4;
        #1;
        check("lpr_only_hi", 32'(O_COND_TRUE), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
